// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the ALU control decoder and execute-unit FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SUBNE = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLL   = 3'b110;
  localparam logic [2:0] ALU_SRL   = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle between operand fetch, the execute ALU and writeback.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             branch_taken;
  logic             busy;

  modport master (
    output in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, branch_taken, busy
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, branch_taken, busy
  );

endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: result and branch sense for one control code.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       alu_control_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             branch_o
);

  logic [WIDTH-1:0] diff;
  logic             lt;

  assign diff = op_a_i - op_b_i;
  assign lt   = $signed(op_a_i) < $signed(op_b_i);

  // Shift codes fall through to ADD; the iterative shifter lives in the execute unit.
  always_comb begin
    result_o = op_a_i + op_b_i;
    branch_o = 1'b0;
    case (alu_control_i)
      ALU_SUB: begin
        result_o = diff;
        branch_o = (diff == '0);
      end
      ALU_SUBNE: begin
        result_o = diff;
        branch_o = (diff != '0);
      end
      ALU_OR:  result_o = op_a_i | op_b_i;
      ALU_AND: result_o = op_a_i & op_b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, lt};
      default: result_o = op_a_i + op_b_i;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshake.
// Define ALU_EXEC_SHIFT_EN to build the iterative one-bit-per-cycle SLL/SRL.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             branch_q;
  logic             out_valid_q;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] core_result;
  logic             core_branch;

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .alu_control_i (bus.alu_control),
    .op_a_i        (bus.op_a),
    .op_b_i        (bus.op_b),
    .result_o      (core_result),
    .branch_o      (core_branch)
  );

`ifdef ALU_EXEC_SHIFT_EN
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shifted;
  logic [ShW-1:0]   cnt_q;
  logic [ShW-1:0]   amt;
  logic             right_q;
  logic             busy_q;
  logic             is_shift;

  assign amt      = bus.op_b[ShW-1:0];
  assign is_shift = (bus.alu_control == ALU_SLL) || (bus.alu_control == ALU_SRL);
  assign shifted  = right_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      result_q    <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      shreg_q     <= '0;
      cnt_q       <= '0;
      right_q     <= 1'b0;
      busy_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
`ifdef ALU_EXEC_SHIFT_EN
            if (is_shift && (amt != '0)) begin
              shreg_q     <= bus.op_a;
              cnt_q       <= amt;
              right_q     <= bus.alu_control[0];
              // Busy drops one cycle early: the final shift lands directly in result_q.
              busy_q      <= (amt != ShW'(1));
              out_valid_q <= 1'b0;
              state_q     <= StShift;
            end else if (is_shift) begin
              result_q    <= bus.op_a;
              zero_q      <= (bus.op_a == '0);
              branch_q    <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
`else
            begin
`endif
              result_q    <= core_result;
              zero_q      <= (core_result == '0);
              branch_q    <= core_branch;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end else if ((state_q == StDone) && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
`ifdef ALU_EXEC_SHIFT_EN
        StShift: begin
          if (cnt_q == ShW'(1)) begin
            result_q    <= shifted;
            zero_q      <= (shifted == '0);
            branch_q    <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            shreg_q <= shifted;
            cnt_q   <= cnt_q - ShW'(1);
            if (cnt_q == ShW'(2)) begin
              busy_q <= 1'b0;
            end
          end
        end
`endif
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.zero         = zero_q;
  assign bus.branch_taken = branch_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake/reset sequences and
// randomized operations against a behavioural model. Follows ALU_EXEC_SHIFT_EN like the RTL.
module tb_alu_exec_unit;
  import alu_pkg::*;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        br;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: what each code means arithmetically, plus its latency.
  function automatic void model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br, output int lat);
    int amt;
    amt = int'(b % 32);
    br  = 1'b0;
    lat = 1;
    case (c)
      3'd0: r = a + b;
      3'd1: begin r = a - b; br = (a == b); end
      3'd2: begin r = a - b; br = (a != b); end
      3'd3: r = a | b;
      3'd4: r = a & b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
`ifdef ALU_EXEC_SHIFT_EN
        r   = (c == 3'd6) ? (a << amt) : (a >> amt);
        lat = (amt == 0) ? 1 : amt;
`else
        r = a + b;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic br,
                        output int lat, output int bc);
    chk("in_ready_on_offer", bus.in_ready, 1);
    bus.in_valid    = 1'b1;
    bus.alu_control = c;
    bus.op_a        = a;
    bus.op_b        = b;
    @(posedge clk); #1;
    // Scramble operands after accept; the operation in flight must not see them.
    bus.in_valid    = 1'b0;
    bus.alu_control = 3'($urandom);
    bus.op_a        = $urandom;
    bus.op_b        = $urandom;
    lat = 1;
    bc  = 0;
    while (!bus.out_valid && lat < 100) begin
      bc += int'(bus.busy);
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_within_bound", bus.out_valid, 1);
    chk("busy_low_at_done", bus.busy, 0);
    r  = bus.result;
    z  = bus.zero;
    br = bus.branch_taken;
  endtask

  task automatic verify_op(input string name, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ez,
                           input logic ebr, input int elat);
    logic [31:0] r;
    logic        z, br;
    int          lat, bc;
    run_op(c, a, b, r, z, br, lat, bc);
    chk({name, ".result"}, r, er);
    chk({name, ".zero"}, z, ez);
    chk({name, ".branch"}, br, ebr);
    chk({name, ".latency"}, lat, elat);
    chk({name, ".busy_cycles"}, bc, elat - 1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".out_valid"}, bus.out_valid, 0);
    chk({name, ".result"}, bus.result, 0);
    chk({name, ".zero"}, bus.zero, 0);
    chk({name, ".branch"}, bus.branch_taken, 0);
    chk({name, ".busy"}, bus.busy, 0);
  endtask

  task automatic add_vec(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic z, input logic br, input int lat);
    vec_t v;
    v.code = c; v.a = a; v.b = b; v.res = r; v.zero = z; v.br = br; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] r, a, b, er;
    logic        ebr;
    int          elat;
    logic [2:0]  c;
    logic [2:0]  bb_code[5];
    logic [31:0] bb_a[5], bb_b[5];

    n_tests = 0;
    n_fail  = 0;

    add_vec(ALU_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1);
    add_vec(ALU_ADD,   32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 1);
    add_vec(ALU_SUB,   32'd5,         32'd5,         32'h0,         1'b1, 1'b1, 1);
    add_vec(ALU_SUBNE, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0, 1);
    add_vec(ALU_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    add_vec(ALU_SUBNE, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b1, 1);
    add_vec(ALU_SLT,   32'hFFFF_FFFE, 32'd3,         32'h1,         1'b0, 1'b0, 1);
    add_vec(ALU_SLT,   32'd3,         32'hFFFF_FFFE, 32'h0,         1'b1, 1'b0, 1);
    add_vec(ALU_SLT,   32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1);
    add_vec(ALU_SLT,   32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b1, 1'b0, 1);
    add_vec(ALU_OR,    32'hF0,        32'h0F,        32'hFF,        1'b0, 1'b0, 1);
    add_vec(ALU_AND,   32'hF0,        32'h3C,        32'h30,        1'b0, 1'b0, 1);
    add_vec(ALU_AND,   32'hF0,        32'h0F,        32'h0,         1'b1, 1'b0, 1);
`ifdef ALU_EXEC_SHIFT_EN
    add_vec(ALU_SLL,   32'h1,         32'd31,        32'h8000_0000, 1'b0, 1'b0, 31);
    add_vec(ALU_SRL,   32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    add_vec(ALU_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 4);
    add_vec(ALU_SLL,   32'h8000_0001, 32'd1,         32'h2,         1'b0, 1'b0, 1);
    add_vec(ALU_SLL,   32'h8000_0000, 32'd2,         32'h0,         1'b1, 1'b0, 2);
    add_vec(ALU_SLL,   32'hF0,        32'h20,        32'hF0,        1'b0, 1'b0, 1);
`else
    add_vec(ALU_SLL,   32'd7,         32'd8,         32'd15,        1'b0, 1'b0, 1);
    add_vec(ALU_SRL,   32'hFFFF_FFFF, 32'd1,         32'h0,         1'b1, 1'b0, 1);
`endif

    // Reset
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.alu_control = 3'd0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    chk("reset.in_ready", bus.in_ready, 1);

    foreach (vecs[i]) begin
      verify_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res,
                vecs[i].zero, vecs[i].br, vecs[i].lat);
    end

    // Consumer stalls with a new op already offered; released in the same cycle it is taken.
    @(posedge clk); #1;
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_OR;
    bus.op_a        = 32'hF0;
    bus.op_b        = 32'h0F;
    @(posedge clk); #1;
    bus.alu_control = ALU_AND;
    bus.op_b        = 32'h3C;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d.result", i), bus.result, 32'hFF);
      chk($sformatf("stall%0d.out_valid", i), bus.out_valid, 1);
      chk($sformatf("stall%0d.in_ready", i), bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release.out_valid", bus.out_valid, 1);
    chk("release.result", bus.result, 32'h30);
    chk("release.zero", bus.zero, 0);

    // Back-to-back single-cycle ops: one result per cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bb_code[i] = 3'($urandom_range(0, 5));
      bb_a[i]    = $urandom;
      bb_b[i]    = (i == 2) ? bb_a[i] : $urandom;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = 1'b1;
      bus.alu_control = bb_code[i];
      bus.op_a        = bb_a[i];
      bus.op_b        = bb_b[i];
      chk($sformatf("b2b%0d.in_ready", i), bus.in_ready, 1);
      @(posedge clk); #1;
      model(bb_code[i], bb_a[i], bb_b[i], er, ebr, elat);
      chk($sformatf("b2b%0d.out_valid", i), bus.out_valid, 1);
      chk($sformatf("b2b%0d.result", i), bus.result, er);
      chk($sformatf("b2b%0d.zero", i), bus.zero, er == 0);
      chk($sformatf("b2b%0d.branch", i), bus.branch_taken, ebr);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain.out_valid", bus.out_valid, 0);

    // Reset while a result waits in DONE.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_control = ALU_SUB;
    bus.op_a      = 32'd9;
    bus.op_b      = 32'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre_reset_done.branch", bus.branch_taken, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_done");
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_done.in_ready", bus.in_ready, 1);

`ifdef ALU_EXEC_SHIFT_EN
    // Reset in the middle of a shift.
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_SLL;
    bus.op_a        = 32'h3;
    bus.op_b        = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_shift.busy", bus.busy, 1);
    chk("mid_shift.in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_shift");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_shift.in_ready", bus.in_ready, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("after_reset_shift.no_stale_valid", bus.out_valid, 0);
`endif
    verify_op("post_reset_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    // Randomized operations against the model.
    for (int i = 0; i < 250; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 7) == 0) b = b & 32'hFFFF_FFE0;
      model(c, a, b, er, ebr, elat);
      verify_op($sformatf("rnd%0d_c%0d", i, c), c, a, b, er, er == 0, ebr, elat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute-stage ALU that consumes the 3-bit ALU control code produced by the processor's ALU control decoder, together with two operands, through a valid/ready handshake. It returns a registered result, a zero flag, and a branch-taken indication. The block sits between decode/operand fetch and writeback/branch resolution. An optional iterative shifter adds multi-cycle operations.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, ≥ 8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation this cycle
- alu_control  in  3  operation code from the ALU control decoder
- op_a  in  WIDTH  first operand
- op_b  in  WIDTH  second operand; low log2(WIDTH) bits are the shift amount
- out_valid  out  1  result registers hold a completed operation
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- branch_taken  out  1  registered branch condition
- busy  out  1  a shift is in progress

## Operation
- Control codes:
  - 000 ADD: a+b, modulo 2^WIDTH.
  - 001 SUB, BEQ sense: a−b; branch_taken = zero.
  - 010 SUB, BNE sense: a−b; branch_taken = !zero.
  - 011 OR.
  - 100 AND.
  - 101 SLT: result = {0…, $signed(a) < $signed(b)}.
  - 110 SLL, 111 SRL: with the macro only. Without it, both codes execute as ADD.
- branch_taken is 0 for every code except 001 and 010.
- zero is computed from the final result.
- Carries and overflow are discarded; no flags beyond zero.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On accept, a single-cycle code registers its outputs and moves to DONE. A shift code with amount 0 also moves to DONE, with result=a. A shift with nonzero amount loads the shift register with a and the counter with the amount, then moves to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle the register shifts by one bit, logical, zero fill, and the counter decrements. When the counter reaches 1, the final value registers and the FSM moves to DONE.
  - DONE: out_valid=1; result, zero and branch_taken are held stable until the handshake.
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=1 with in_valid=1: in_ready=1 and the new operation is accepted in the same cycle. The FSM stays in DONE for a single-cycle code, or goes to SHIFT.
    - out_ready=0: in_ready=0; hold.
- Inputs are sampled only on accept; later changes do not affect the operation in flight.
- Reset values: state IDLE, out_valid 0, result 0, zero 0, branch_taken 0, busy 0, in_ready 1 once reset deasserts.
- Reset asserted mid-shift or in DONE aborts immediately; the pending result is discarded.

## Timing
- Single-cycle codes: accept on edge N; out_valid high after edge N (latency 1).
- Shift by k>0: out_valid high after edge N+k (latency k); busy high during cycles N+1…N+k−1.
- Back-to-back single-cycle ops with out_ready held high: throughput one op per cycle.
- No combinational path from in_valid or operands to any output except in_ready.
- in_ready depends combinationally on state and out_ready only.

## Configuration
- ALU_EXEC_SHIFT_EN defined:
  - Codes 110/111 perform iterative SLL/SRL.
  - The SHIFT state, counter and busy logic are present.
- ALU_EXEC_SHIFT_EN undefined:
  - Codes 110/111 execute as ADD with latency 1.
  - The SHIFT state and counter are not built; busy is tied to 0.

## Structure
- Shared package alu_pkg:
  - localparams ALU_ADD, ALU_SUB, ALU_SUBNE, ALU_OR, ALU_AND, ALU_SLT, ALU_SLL, ALU_SRL (3-bit), shared with the ALU control decoder.
  - State encoding IDLE/SHIFT/DONE.
- One natural sub-module: alu_core. It is a combinational single-cycle result and branch-sense function of (alu_control, op_a, op_b), instantiated by alu_exec_unit. The FSM, handshake and shifter stay in alu_exec_unit.

## Test plan
- Reset, then ADD with a=0xFFFF_FFFF, b=1 → result 0x0000_0000, zero=1, branch_taken=0, out_valid one cycle after accept.
- Code 001 then 010, both with a=b=5 → first gives zero=1, branch_taken=1; second gives zero=1, branch_taken=0.
- SLT with a=0xFFFF_FFFE (−2), b=3 → result 1. Swapped operands → result 0, zero=1.
- Hold out_ready=0 for 4 cycles after an OR of 0xF0 with 0x0F → result 0xFF held stable, in_ready=0; then out_ready=1 with a new AND of 0xF0 with 0x3C offered → accepted the same cycle, next result 0x30.
- Macro on: SLL a=1, b=31 → busy for 30 cycles, out_valid at accept+31, result 0x8000_0000. SRL b=0 → latency 1, result=a.
- Assert rst_n low in the middle of a shift → all outputs return to their reset values immediately; the next ADD 2+3 gives 5 with latency 1.
